// File: rtl/mem_scan_pkg.sv
// Shared types, CRC constants and the CRC-32/MPEG-2 step function for the readback scanner.
package mem_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Non-reflected CRC update. Only the low 'width' bits of data are used,
  // and they are consumed MSB-first. There is no final XOR.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [31:0] data,
                                             input int          width);
    logic [31:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        fb = c[31] ^ data[i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_accum.sv
// Signature register: restarts from CRC_INIT on clr and folds in one memory word on each en.
module crc32_accum
  import mem_scan_pkg::*;
#(
  parameter int WID_MEM = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [WID_MEM-1:0] data,
  output logic [31:0]        crc,
  output logic [31:0]        crc_next
);

  logic [31:0] data_ext;

  assign data_ext = 32'(data);
  assign crc_next = crc32_step(crc, data_ext, WID_MEM);

  // Hold the running CRC; clr wins over en so a new sweep always starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/mem_readback_scanner.sv
// Sweeps the memory address range, feeds the returning words into a CRC-32 and a
// non-zero counter, then compares the final signature with a golden value.
module mem_readback_scanner
  import mem_scan_pkg::*;
#(
  parameter int WID_MEM   = 32,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        expected_sig,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy,
  output logic               done,
  output logic [31:0]        signature,
  output logic               match,
  output logic [31:0]        nz_count
);

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

  scan_state_t state;
  logic        addr_vld;
  logic        data_vld;
  logic        launch;
  logic [31:0] crc_next;

  // addr_vld marks that raddr carries a live address; data_vld marks that
  // mem_dout carries the word for it and must be consumed at this edge.
  assign launch = (state == ST_IDLE) && start;
  assign busy   = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done   = (state == ST_DONE);

  crc32_accum #(
    .WID_MEM(WID_MEM)
  ) u_crc (
    .clk     (clk),
    .reset   (reset),
    .clr     (launch),
    .en      (data_vld),
    .data    (mem_dout),
    .crc     (signature),
    .crc_next(crc_next)
  );

  // Sweep control: address counter, valid pipeline, FSM, result latching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      raddr    <= '0;
      addr_vld <= 1'b0;
      data_vld <= 1'b0;
      match    <= 1'b0;
      nz_count <= '0;
    end else begin
      data_vld <= addr_vld;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ISSUE;
            raddr    <= '0;
            addr_vld <= 1'b1;
            match    <= 1'b0;
            nz_count <= '0;
          end
        end
        ST_ISSUE: begin
          if (raddr == LAST_ADDR) begin
            state    <= ST_DRAIN;
            addr_vld <= 1'b0;
          end else begin
            raddr    <= raddr + 32'd1;
            addr_vld <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // The word in data_vld is the last one; it is folded in on this edge,
          // so the comparison uses the post-update signature.
          if (!addr_vld) begin
            state <= ST_DONE;
            match <= (crc_next == expected_sig);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (data_vld && (mem_dout != '0)) begin
        nz_count <= nz_count + 32'd1;
      end
    end
  end

endmodule
